// File: rtl/accum_drain_ctrl.sv
// Drains aligned accumulator column pairs into the result buffer via a small FIFO.
// Optional idle timeout in COLLECT is enabled by defining ACCUM_DRAIN_TIMEOUT_EN.
module accum_drain_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int CNT_W          = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  row_count,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    output logic              align_clear,
    input  logic              aligned_valid,
    input  logic [15:0]       align_col0,
    input  logic [15:0]       align_col1,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow_err,
    output logic              extra_err
`ifdef ACCUM_DRAIN_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLEAR   = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [1:0]        state;
    logic [CNT_W-1:0]  rows;
    logic [CNT_W-1:0]  captured;
    logic [CNT_W-1:0]  written;
    logic [CNT_W-1:0]  written_nxt;
    logic [ADDR_W-1:0] base;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]    rd_ptr;
    logic [PTR_W:0]    wr_ptr;
    logic              empty;
    logic              full;
    logic              in_collect;
    logic              capture;
    logic              extra;
    logic              pop;
    logic              push;
    logic              drop;
    logic              collect_done;
    logic              timeout;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[PTR_W] != wr_ptr[PTR_W]) &&
                   (rd_ptr[PTR_W-1:0] == wr_ptr[PTR_W-1:0]);

    assign in_collect = (state == S_COLLECT);
    assign capture    = in_collect && aligned_valid && (captured < rows);
    assign extra      = in_collect && aligned_valid && (captured >= rows);

    assign wr_valid = !empty;
    assign pop      = wr_valid && wr_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = capture && (!full || pop);
    assign drop     = capture && full && !pop;

    assign written_nxt  = written + CNT_W'(1);
    assign collect_done = (written == rows) || (pop && (written_nxt == rows));

    assign wr_addr     = base + ADDR_W'(written);
    assign wr_data     = mem[rd_ptr[PTR_W-1:0]];
    assign align_clear = (state == S_CLEAR);
    assign done        = (state == S_DONE);
    assign busy        = (state != S_IDLE);

`ifdef ACCUM_DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt;

    assign timeout = in_collect && !aligned_valid && !pop &&
                     (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (abort || !in_collect || aligned_valid || pop)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TO_W'(1);
            if (!abort && state == S_IDLE && start)
                timeout_err <= 1'b0;
            else if (!abort && timeout)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= {align_col1, align_col0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rows         <= '0;
            base         <= '0;
            captured     <= '0;
            written      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            overflow_err <= 1'b0;
            extra_err    <= 1'b0;
        end else if (abort) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (capture)
                captured <= captured + CNT_W'(1);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                written <= written_nxt;
            end
            if (drop)
                overflow_err <= 1'b1;
            if (extra)
                extra_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_CLEAR;
                        rows         <= row_count;
                        base         <= base_addr;
                        captured     <= '0;
                        written      <= '0;
                        overflow_err <= 1'b0;
                        extra_err    <= 1'b0;
                    end
                end
                S_CLEAR: state <= S_COLLECT;
                S_COLLECT: begin
                    if (timeout) begin
                        state  <= S_DONE;
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                    end else if (collect_done) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/accum_drain_ctrl.md
Name: accum_drain_ctrl

Overview:
Sequences draining of aligned accumulator results for one inference into the result buffer.
- On start: pulses the aligner's clear, then collects the requested number of aligned column pairs.
- Buffers collected pairs in a small FIFO that absorbs write-port backpressure, then writes them to consecutive buffer addresses.
- Sits between the accumulator alignment stage and the unified/result buffer write port; driven by the top-level inference FSM.

Parameters:
ADDR_W, 8, result buffer address width
CNT_W, 8, width of row_count and internal counters
FIFO_DEPTH, 4, pending-pair buffer entries (power of two, >=2)
TIMEOUT_CYCLES, 256, idle-cycle limit in COLLECT (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  command strobe, accepted only when busy=0
row_count  in  CNT_W  pairs to drain; sampled on accepted start
base_addr  in  ADDR_W  first write address; sampled on accepted start
abort  in  1  synchronous abandon of the current drain
align_clear  out  1  one-cycle clear pulse to the aligner
aligned_valid  in  1  aligned pair valid
align_col0  in  16  signed aligned column 0
align_col1  in  16  signed aligned column 1
wr_valid  out  1  write request
wr_ready  in  1  buffer accepts the write
wr_addr  out  ADDR_W  write address
wr_data  out  32  {align_col1, align_col0}
busy  out  1  high from start acceptance through the DONE cycle
done  out  1  one-cycle completion pulse
overflow_err  out  1  sticky: pair dropped because the FIFO was full
extra_err  out  1  sticky: aligned_valid received after row_count pairs were captured

Behaviour:
- Reset values: every output 0; FIFO empty; counters 0; state IDLE.
- States:
  - IDLE -> CLEAR on start.
  - CLEAR: align_clear=1 for exactly this one cycle -> COLLECT.
  - COLLECT -> DONE when written==row_count.
  - DONE: done=1 for one cycle -> IDLE.
- Start acceptance: start while busy=1 is ignored. An accepted start latches row_count and base_addr, zeroes the captured and written counters, and clears both sticky errors.
- row_count=0: IDLE -> CLEAR -> COLLECT -> DONE. No writes occur; done asserts 3 cycles after start.
- Capture (COLLECT only):
  - aligned_valid && captured<row_count: push {col1,col0}; captured++.
  - aligned_valid && captured==row_count: drop the pair; set extra_err.
  - aligned_valid outside COLLECT is ignored, with no error.
- FIFO push while full: set overflow_err and drop the pair; captured still increments, so the drain still terminates.
- Push and pop in the same cycle while full is legal and is not an overflow.
- Write port:
  - wr_valid = FIFO non-empty, with no bypass. Latency is aligned_valid -> wr_valid 1 cycle.
  - Transfer occurs when wr_valid && wr_ready; the FIFO pops and written++.
  - wr_addr = base_addr + written, wrapping modulo 2^ADDR_W.
  - wr_data and wr_addr are held stable while wr_valid && !wr_ready.
- Completion on dropped pairs: because overflow drops pairs, written can never reach row_count. In that case the drain ends with done only via the timeout feature or via abort.
- abort, in any state: go to IDLE next cycle, flush the FIFO, busy=0, no done. Sticky errors are retained.
- Priority: reset > abort > normal operation.
- reset mid-operation: identical to abort, except that sticky errors are also cleared.

Optional Feature:
- Macro: ACCUM_DRAIN_TIMEOUT_EN.
- Enabled:
  - Adds output timeout_err (1 bit, sticky, cleared on start acceptance).
  - In COLLECT, a counter increments every cycle with no aligned_valid and no write transfer, and resets otherwise.
  - On reaching TIMEOUT_CYCLES: set timeout_err, flush the FIFO, enter DONE (done pulses).
- Disabled: no timeout_err port and no counter; COLLECT waits indefinitely.

Test Plan:
1. start, row_count=4, base_addr=0x10, wr_ready=1, 4 consecutive aligned_valid pairs -> align_clear pulse 1 cycle after start; writes to 0x10..0x13 with matching wr_data; done 1 cycle after the last write; no errors.
2. row_count=3, wr_ready held low for 10 cycles during 3 aligned_valid pulses -> FIFO holds 3 entries; after wr_ready rises, 3 writes in order; overflow_err=0.
3. FIFO_DEPTH=4, wr_ready=0, 6 aligned_valid pulses with row_count=6 -> overflow_err=1; 4 writes after wr_ready rises; done only via timeout (feature on) or abort.
4. base_addr=0xFE, row_count=3 -> writes to addresses 0xFE, 0xFF, 0x00.
5. row_count=2 with 3 aligned_valid pulses -> 2 writes, extra_err=1, done pulses; start issued mid-drain -> ignored.
6. abort in COLLECT after 1 write -> IDLE next cycle, busy=0, no done, FIFO empty; a following start runs normally.
